// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef logic [1:0] md_state_t;

  localparam md_state_t StIdle = 2'd0;
  localparam md_state_t StMul  = 2'd1;
  localparam md_state_t StDiv  = 2'd2;
  localparam md_state_t StDone = 2'd3;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result signs and fast-path detection.
// MULDIV_ZERO_BYPASS_EN adds a zero-operand fast path returning 0.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic [XLEN-1:0] abs_a_o,
  output logic [XLEN-1:0] abs_b_o,
  output logic            neg_result_o,
  output logic            rem_neg_o,
  output logic            fast_path_o,
  output logic [XLEN-1:0] fast_result_o
);

  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  logic is_div, a_signed, b_signed, a_neg, b_neg;
  logic div_zero, div_ovf, zero_byp;

  always_comb begin
    is_div   = funct3_i[2];
    a_signed = (funct3_i == MD_MUL) || (funct3_i == MD_MULH) || (funct3_i == MD_MULHSU) ||
               (funct3_i == MD_DIV) || (funct3_i == MD_REM);
    b_signed = (funct3_i == MD_MUL) || (funct3_i == MD_MULH) ||
               (funct3_i == MD_DIV) || (funct3_i == MD_REM);
    a_neg    = a_signed && src_a_i[XLEN-1];
    b_neg    = b_signed && src_b_i[XLEN-1];

    // -IntMin wraps to IntMin, which is still the correct unsigned magnitude
    abs_a_o      = a_neg ? -src_a_i : src_a_i;
    abs_b_o      = b_neg ? -src_b_i : src_b_i;
    neg_result_o = a_neg ^ b_neg;
    rem_neg_o    = a_neg;

    div_zero = is_div && (src_b_i == '0);
    div_ovf  = is_div && !funct3_i[0] && (src_a_i == IntMin) && (src_b_i == '1);
`ifdef MULDIV_ZERO_BYPASS_EN
    zero_byp = is_div ? ((src_a_i == '0) && (src_b_i != '0))
                      : ((src_a_i == '0) || (src_b_i == '0));
`else
    zero_byp = 1'b0;
`endif
    fast_path_o = div_zero || div_ovf || zero_byp;

    // funct3[1] selects remainder for the divide group
    if (div_zero) begin
      fast_result_o = funct3_i[1] ? src_a_i : '1;
    end else if (div_ovf) begin
      fast_result_o = funct3_i[1] ? '0 : src_a_i;
    end else begin
      fast_result_o = '0;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) unit with pipeline stall control.
// Optional zero-operand fast path under MULDIV_ZERO_BYPASS_EN (see muldiv_operand_prep).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   abs_a, abs_b, fast_result;
  logic              neg_result, rem_neg, fast_path;

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3_i      (funct3),
    .src_a_i       (src_a),
    .src_b_i       (src_b),
    .abs_a_o       (abs_a),
    .abs_b_o       (abs_b),
    .neg_result_o  (neg_result),
    .rem_neg_o     (rem_neg),
    .fast_path_o   (fast_path),
    .fast_result_o (fast_result)
  );

  // prod_q is {acc, multiplier} for multiply and {remainder, quotient} for divide
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] mul_next, div_next, mul_signed;
  logic [XLEN-1:0]   quot, rem, mul_res, div_res;
  logic              last_iter;

  always_comb begin
    sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {sum, prod_q[XLEN-1:1]};

    shifted  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    diff     = shifted - {1'b0, mcand_q};
    div_next = diff[XLEN] ? {shifted[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};

    mul_signed = neg_q ? -mul_next : mul_next;
    mul_res    = (op_q == MD_MUL) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    quot       = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    rem        = rem_neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    div_res    = op_q[1] ? rem : quot;
    last_iter  = (cnt_q == CNT_W'(XLEN - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    result_d  = result_q;

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d      = funct3;
          neg_d     = neg_result;
          rem_neg_d = rem_neg;
          cnt_d     = '0;
          if (fast_path) begin
            result_d = fast_result;
            state_d  = StDone;
          end else begin
            mcand_d = abs_b;
            prod_d  = {{XLEN{1'b0}}, abs_a};
            state_d = funct3[2] ? StDiv : StMul;
          end
        end
      end
      StMul: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) begin
          result_d = mul_res;
          state_d  = StDone;
        end
      end
      StDiv: begin
        prod_d = div_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) begin
          result_d = div_res;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // A killed op must leave no trace on the architectural result
    if (flush) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
    end
  end

  assign stall  = (start && (state_q == StIdle)) || (state_q == StMul) || (state_q == StDiv);
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, random ops against an
// arithmetic reference model, and flush / reset corner sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    int                 ia, ib, iq;
    logic               ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (f)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (ovf) return a;
        iq = ia / ib;
        return iq;
      end
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        iq = ia % ib;
        return iq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    bit fast;
    fast = (f[2] && b == 0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hffff_ffff);
`ifdef MULDIV_ZERO_BYPASS_EN
    fast = fast || (!f[2] && (a == 0 || b == 0)) || (f[2] && a == 0 && b != 0);
`endif
    return fast ? 1 : 33;
  endfunction

  // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the next IDLE cycle.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    bit          got;
    int          n;
    logic [31:0] res;
    logic        sd;
    got = 0; n = 0; res = '0; sd = 1'b0;
    start = 1'b1; funct3 = f; src_a = a; src_b = b;
    #1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done) begin
        got = 1; res = result; sd = stall;
      end else begin
        if (stall) n++;
        @(negedge clk); #1;
        // Operands may change after accept without effect
        funct3 = 3'($urandom); src_a = $urandom; src_b = $urandom;
        #1;
      end
    end
    start = 1'b0;
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " result"}, res, exp);
    chk({name, " stall_cycles"}, n, lat);
    chk({name, " stall_in_done"}, 32'(sd), 32'd0);
    @(negedge clk); #1;
    chk({name, " done_pulse_len"}, 32'(done), 32'd0);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0]  f;
    int          seen;

    vt[0]  = '{3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 33};
    vt[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vt[2]  = '{3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 33};
    vt[3]  = '{3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 33};
    vt[4]  = '{3'd4, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 33};
    vt[5]  = '{3'd6, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 33};
    vt[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33};
    vt[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33};
    vt[8]  = '{3'd4, 32'd5, 32'd0, 32'hffff_ffff, 1};
    vt[9]  = '{3'd6, 32'd5, 32'd0, 32'd5, 1};
    vt[10] = '{3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1};
    vt[11] = '{3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0, 1};
    vt[12] = '{3'd5, 32'd5, 32'd0, 32'hffff_ffff, 1};
    vt[13] = '{3'd7, 32'd5, 32'd0, 32'd5, 1};
`ifdef MULDIV_ZERO_BYPASS_EN
    vt[14] = '{3'd0, 32'd0, 32'd9, 32'd0, 1};
`else
    vt[14] = '{3'd0, 32'd0, 32'd9, 32'd0, 33};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed table, issued back-to-back
    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);
    end

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rnd%0d f=%0d a=%h b=%h", i, f, a, b), f, a, b, model(f, a, b),
             model_lat(f, a, b));
    end

    // Flush on the 10th divide iteration, then a fresh MUL right after
    prev = result;
    start = 1'b1; funct3 = 3'd5; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush result", result, prev);
    run_op("post_flush mul", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // flush together with start in IDLE must not accept
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start busy", 32'(busy), 32'd0);
    chk("flush_start done", 32'(done), 32'd0);

    // Reset mid-multiply: op is lost
    start = 1'b1; funct3 = 3'd0; src_a = 32'd11; src_b = 32'd13;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst result", result, 32'd0);
    start = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done || busy) seen++;
    end
    chk("midrst no done after release", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
